// File: rtl/freqmon_pkg.sv
// Shared types and defaults for the clock frequency monitor.
package freqmon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam int GATE_CYCLES_DEF  = 6000;
    localparam int EXP_COUNT_DEF    = 600;
    localparam int TOL_DEF          = 6;
    localparam int LOCK_WINDOWS_DEF = 4;
    localparam int CW_DEF           = 16;
    localparam int STUCK_CYCLES_DEF = 64;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int GATE_CNT_W_DEF = width_for(GATE_CYCLES_DEF);

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous clock-like input followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Measures the frequency of meas_clk against clk by counting its rising edges
// over a fixed gate window, flags in-range counts and debounces a lock.
// Optional stuck-clock detection is built when FREQMON_STUCK_DET_EN is defined.
module clk_freq_monitor
    import freqmon_pkg::*;
#(
    parameter int GATE_CYCLES  = GATE_CYCLES_DEF,
    parameter int EXP_COUNT    = EXP_COUNT_DEF,
    parameter int TOL          = TOL_DEF,
    parameter int LOCK_WINDOWS = LOCK_WINDOWS_DEF,
    parameter int CW           = CW_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          meas_clk,
    output logic [CW-1:0] count,
    output logic          count_valid,
    output logic          in_range,
    output logic          lock,
    output logic          stuck
);

    localparam int GW = width_for(GATE_CYCLES);
    localparam int LW = width_for(LOCK_WINDOWS + 1);

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_WINDOWS);

    state_e        state_q, state_d;
    logic [GW-1:0] gate_cnt_q, gate_cnt_d;
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic [CW-1:0] edge_cnt_fin;
    logic [CW-1:0] count_q, count_d;
    logic          count_valid_q, count_valid_d;
    logic          in_range_q, in_range_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_q, lock_d;
    logic          edge_p;
    logic          stuck_hit;

    // Edge counter saturates at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // |c - EXP_COUNT| <= TOL evaluated on CW+1 signed bits so nothing wraps.
    function automatic logic in_tol(input logic [CW-1:0] c);
        logic signed [CW:0] diff;
        diff = $signed({1'b0, c}) - $signed((CW+1)'(EXP_COUNT));
        if (diff < 0) diff = -diff;
        return diff <= $signed((CW+1)'(TOL));
    endfunction

    sync_edge_det u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (meas_clk),
        .edge_o  (edge_p)
    );

`ifdef FREQMON_STUCK_DET_EN
    localparam int SW = width_for(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);

    logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic          stuck_q, stuck_d;

    // Count edge-free enabled cycles; any edge or disable restarts the count.
    always_comb begin
        stuck_cnt_d = stuck_cnt_q;
        stuck_d     = stuck_q;
        stuck_hit   = 1'b0;
        if (!enable || edge_p) begin
            stuck_cnt_d = '0;
            stuck_d     = 1'b0;
        end else if (stuck_cnt_q == STUCK_MAX) begin
            stuck_d   = 1'b1;
            stuck_hit = 1'b1;
        end else begin
            stuck_cnt_d = stuck_cnt_q + 1'b1;
        end
    end

    // Stuck detector state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
            stuck_q     <= stuck_d;
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck_hit = 1'b0;
    assign stuck     = 1'b0;
`endif

    // Window FSM: gate timing, edge accumulation, report and lock debounce.
    always_comb begin
        state_d       = state_q;
        gate_cnt_d    = gate_cnt_q;
        edge_cnt_d    = edge_cnt_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        in_range_d    = in_range_q;
        lock_cnt_d    = lock_cnt_q;
        lock_d        = lock_q;
        edge_cnt_fin  = edge_p ? sat_inc(edge_cnt_q) : edge_cnt_q;

        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                if (enable) state_d = GATE;
            end
            GATE: begin
                if (!enable) begin
                    // Abort: window discarded, lock must be re-earned.
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    lock_cnt_d = '0;
                    lock_d     = 1'b0;
                end else begin
                    edge_cnt_d = edge_cnt_fin;
                    if (gate_cnt_q == GATE_LAST) begin
                        // Registered outputs land in the REPORT cycle.
                        state_d       = REPORT;
                        gate_cnt_d    = '0;
                        count_d       = edge_cnt_fin;
                        count_valid_d = 1'b1;
                        in_range_d    = in_tol(edge_cnt_fin);
                        if (in_tol(edge_cnt_fin)) begin
                            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q
                                                                   : lock_cnt_q + 1'b1;
                            lock_d     = (lock_cnt_d == LOCK_MAX);
                        end else begin
                            lock_cnt_d = '0;
                            lock_d     = 1'b0;
                        end
                    end else begin
                        gate_cnt_d = gate_cnt_q + 1'b1;
                    end
                end
            end
            REPORT: begin
                // An edge during REPORT belongs to the following window.
                gate_cnt_d = '0;
                edge_cnt_d = edge_p ? CW'(1) : '0;
                state_d    = enable ? GATE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stuck_hit) begin
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gate_cnt_q    <= '0;
            edge_cnt_q    <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            in_range_q    <= 1'b0;
            lock_cnt_q    <= '0;
            lock_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gate_cnt_q    <= gate_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            in_range_q    <= in_range_d;
            lock_cnt_q    <= lock_cnt_d;
            lock_q        <= lock_d;
        end
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign in_range    = in_range_q;
    assign lock        = lock_q;

endmodule
